// File: rtl/flow_ctrl_fsm.sv
// flow_ctrl_fsm: RESET/INIT/IDLE/ACTIVE/ERROR sequencer, FIFO threshold holder and arbiter enable.
// Optional ERR_CNT_EN adds a saturating fault-cycle counter on port err_count.
`default_nettype none

module flow_ctrl_fsm #(
  parameter int TH_W     = 3,
  parameter int DEF_AF   = 6,
  parameter int DEF_AE   = 1,
  parameter int IDLE_CYC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            init,
  input  logic [TH_W-1:0] af_in,
  input  logic [TH_W-1:0] ae_in,
  input  logic [7:0]      fifo_empty,
  input  logic [7:0]      fifo_err,
  output logic [2:0]      state,
  output logic [TH_W-1:0] af_th,
  output logic [TH_W-1:0] ae_th,
  output logic            arb_en,
  output logic            idle,
  output logic            error_out,
`ifdef ERR_CNT_EN
  output logic [7:0]      err_count,
`endif
  output logic [7:0]      err_src
);

  localparam int CNT_W = $clog2(IDLE_CYC + 1);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TH_W-1:0]   af_q, af_d, ae_q, ae_d;
  logic [7:0]        err_src_q, err_src_d;
  logic              arb_en_q, arb_en_d;
  logic              idle_q, idle_d;
  logic              error_q, error_d;

  logic w_valid, w_all_empty, w_err;

  assign w_valid     = (ae_in < af_in) && (af_in != '0);
  assign w_all_empty = (fifo_empty == 8'hFF);
  assign w_err       = |fifo_err;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    af_d      = af_q;
    ae_d      = ae_q;
    err_src_d = err_src_q;

    // Fault capture is live everywhere except RESET, including the absorbing ERROR state.
    if (state_q != S_RESET) err_src_d = err_src_q | fifo_err;

    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        if (w_valid) begin
          af_d = af_in;
          ae_d = ae_in;
        end
        if (w_err) begin
          state_d = S_ERROR;
        end else if (!init) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_IDLE: begin
        if (w_err) begin
          state_d = S_ERROR;
        end else if (init) begin
          state_d = S_INIT;
        end else if (!w_all_empty) begin
          state_d = S_ACTIVE;
          cnt_d   = '0;
        end
      end
      S_ACTIVE: begin
        if (w_err) begin
          state_d = S_ERROR;
        end else if (init) begin
          state_d = S_INIT;
        end else if (w_all_empty) begin
          if (cnt_q == CNT_W'(IDLE_CYC - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_RESET;
    endcase

    arb_en_d = (state_d == S_IDLE) || (state_d == S_ACTIVE);
    idle_d   = (state_d == S_IDLE);
    error_d  = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      af_q      <= TH_W'(DEF_AF);
      ae_q      <= TH_W'(DEF_AE);
      err_src_q <= '0;
      arb_en_q  <= 1'b0;
      idle_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
      err_src_q <= err_src_d;
      arb_en_q  <= arb_en_d;
      idle_q    <= idle_d;
      error_q   <= error_d;
    end
  end

`ifdef ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q != S_RESET) && w_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

  assign state     = state_q;
  assign af_th     = af_q;
  assign ae_th     = ae_q;
  assign arb_en    = arb_en_q;
  assign idle      = idle_q;
  assign error_out = error_q;
  assign err_src   = err_src_q;

endmodule

`default_nettype wire

// File: tb/tb_flow_ctrl_fsm.sv
// Bench for flow_ctrl_fsm: directed scenarios, then random traffic against a behavioural model.
`default_nettype none

module tb_flow_ctrl_fsm;
  localparam int TH_W = 3;
  localparam int IDLE_CYC = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            init = 1'b1;
  logic [TH_W-1:0] af_in = 3'd6;
  logic [TH_W-1:0] ae_in = 3'd1;
  logic [7:0]      fifo_empty = 8'hFF;
  logic [7:0]      fifo_err = 8'h00;
  logic [2:0]      state;
  logic [TH_W-1:0] af_th, ae_th;
  logic            arb_en, idle, error_out;
  logic [7:0]      err_src;
`ifdef ERR_CNT_EN
  logic [7:0]      err_count;
`endif

  flow_ctrl_fsm #(.TH_W(TH_W), .DEF_AF(6), .DEF_AE(1), .IDLE_CYC(IDLE_CYC)) dut (
    .clk(clk), .reset(reset), .init(init), .af_in(af_in), .ae_in(ae_in),
    .fifo_empty(fifo_empty), .fifo_err(fifo_err), .state(state), .af_th(af_th),
    .ae_th(ae_th), .arb_en(arb_en), .idle(idle), .error_out(error_out),
`ifdef ERR_CNT_EN
    .err_count(err_count),
`endif
    .err_src(err_src)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit go = 1'b0;

  // Behavioural model: 0=RESET 1=INIT 2=IDLE 3=ACTIVE 4=ERROR
  int m_state, m_af, m_ae, m_run, m_src, m_ecnt;

  always @(posedge clk or posedge reset) begin
    int ns;
    if (reset) begin
      m_state = 0; m_af = 6; m_ae = 1; m_run = 0; m_src = 0; m_ecnt = 0;
    end else begin
      ns = m_state;
      if (m_state != 0) begin
        m_src = m_src | int'(fifo_err);
        if (fifo_err != 0 && m_ecnt < 255) m_ecnt = m_ecnt + 1;
      end
      if (m_state == 0) ns = 1;
      else if (m_state != 4) begin
        if (m_state == 1 && int'(ae_in) < int'(af_in) && af_in != 0) begin
          m_af = int'(af_in); m_ae = int'(ae_in);
        end
        if (fifo_err != 0) ns = 4;
        else if (init) ns = 1;
        else if (m_state == 1) ns = 2;
        else if (m_state == 2) begin
          if (fifo_empty != 8'hFF) ns = 3;
        end else begin
          if (fifo_empty == 8'hFF) m_run = m_run + 1;
          else m_run = 0;
          if (m_run == IDLE_CYC) ns = 2;
        end
      end
      if (ns != m_state) m_run = 0;
      m_state = ns;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pins both the DUT and the model to a hand-derived value.
  task automatic lit(input string name, input int dut_v, input int mod_v, input int exp);
    chk({name, " dut"}, dut_v, exp);
    chk({name, " model"}, mod_v, exp);
  endtask

  always @(negedge clk) begin
    if (go) begin
      chk("state", int'(state), m_state);
      chk("af_th", int'(af_th), m_af);
      chk("ae_th", int'(ae_th), m_ae);
      chk("arb_en", int'(arb_en), int'(m_state == 2 || m_state == 3));
      chk("idle", int'(idle), int'(m_state == 2));
      chk("error_out", int'(error_out), int'(m_state == 4));
      chk("err_src", int'(err_src), m_src);
`ifdef ERR_CNT_EN
      chk("err_count", int'(err_count), m_ecnt);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(2);
    go = 1'b1;
    // T1 reset release
    reset = 1'b0;
    lit("T1 state", int'(state), m_state, 0);
    step(1);
    lit("T1 state init", int'(state), m_state, 1);
    lit("T1 af", int'(af_th), m_af, 6);
    lit("T1 ae", int'(ae_th), m_ae, 1);
    lit("T1 arb_en", int'(arb_en), int'(m_state == 2 || m_state == 3), 0);
    // T2 programming
    af_in = 3'd5; ae_in = 3'd2;
    step(1);
    init = 1'b0;
    step(1);
    lit("T2 af", int'(af_th), m_af, 5);
    lit("T2 ae", int'(ae_th), m_ae, 2);
    lit("T2 state", int'(state), m_state, 2);
    lit("T2 idle", int'(idle), int'(m_state == 2), 1);
    af_in = 3'd2; ae_in = 3'd4; init = 1'b1;
    step(1);
    lit("T2 reinit", int'(state), m_state, 1);
    step(1);
    lit("T2 keep af", int'(af_th), m_af, 5);
    lit("T2 keep ae", int'(ae_th), m_ae, 2);
    // Equal pair and af=0 are both invalid
    af_in = 3'd3; ae_in = 3'd3;
    step(1);
    af_in = 3'd0; ae_in = 3'd0;
    step(1);
    lit("T2 eq af", int'(af_th), m_af, 5);
    af_in = 3'd5; ae_in = 3'd2; init = 1'b0;
    step(1);
    lit("T2 back idle", int'(state), m_state, 2);
    // T3 activity and idle timeout
    fifo_empty = 8'hFE;
    step(1);
    lit("T3 active", int'(state), m_state, 3);
    fifo_empty = 8'hFF;
    step(3);
    fifo_empty = 8'hFE;
    step(1);
    lit("T3 stay active", int'(state), m_state, 3);
    fifo_empty = 8'hFF;
    step(3);
    lit("T3 three empty", int'(state), m_state, 3);
    step(1);
    lit("T3 to idle", int'(state), m_state, 2);
    // T4 re-init from ACTIVE
    fifo_empty = 8'hFE;
    step(1);
    init = 1'b1;
    step(1);
    lit("T4 init", int'(state), m_state, 1);
    lit("T4 arb_en", int'(arb_en), int'(m_state == 2 || m_state == 3), 0);
    init = 1'b0;
    step(1);
    lit("T4 idle", int'(state), m_state, 2);
    // T5 error beats init
    step(1);
    fifo_err = 8'h10; init = 1'b1;
    step(1);
    lit("T5 error", int'(state), m_state, 4);
    lit("T5 src", int'(err_src), m_src, 8'h10);
    lit("T5 arb_en", int'(arb_en), int'(m_state == 2 || m_state == 3), 0);
    fifo_err = 8'h00; init = 1'b0;
    step(1);
    fifo_err = 8'h01;
    step(1);
    fifo_err = 8'h00;
    lit("T5 src or", int'(err_src), m_src, 8'h11);
    init = 1'b1; step(1); init = 1'b0; step(1);
    lit("T5 absorbing", int'(state), m_state, 4);
`ifdef ERR_CNT_EN
    lit("T6 cnt2", int'(err_count), m_ecnt, 2);
    fifo_err = 8'h01;
    step(300);
    fifo_err = 8'h00;
    lit("T6 sat", int'(err_count), m_ecnt, 255);
`endif
    #2 reset = 1'b1;
    #1;
    lit("T5 reset state", int'(state), m_state, 0);
    lit("T5 reset src", int'(err_src), m_src, 0);
    step(1);
    reset = 1'b0;
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(199) == 0 || (m_state == 4 && $urandom_range(19) == 0)) reset = 1'b1;
      else reset = 1'b0;
      init       = ($urandom_range(15) == 0);
      af_in      = TH_W'($urandom);
      ae_in      = TH_W'($urandom);
      fifo_empty = ($urandom_range(1) == 0) ? 8'hFF : 8'($urandom);
      fifo_err   = ($urandom_range(63) == 0) ? (8'h01 << $urandom_range(7)) : 8'h00;
      step(1);
    end
    reset = 1'b0;
    fifo_err = 8'h00;
    step(1);
    go = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
